// File: rtl/transmitter_pkg.sv
// Shared types and constants for the photonic lane transmitter.
package transmitter_pkg;

    typedef enum logic [1:0] {
        TX_IDLE   = 2'd0,
        TX_SHIFT  = 2'd1,
        TX_PARITY = 2'd2
    } tx_state_t;

    localparam logic TX_DARK = 1'b0;

endpackage

// File: rtl/tx_shift_reg.sv
// WIDTH-bit parallel-load / shift-left register; MSB is the serial output.
module tx_shift_reg
    import transmitter_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             clr_n_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             msb_o
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // Load has priority over shift; vacated LSBs fill with the dark level.
    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = data_i;
        end else if (shift_i) begin
            sr_d = sr_q << 1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n_i) begin
            sr_q <= {WIDTH{TX_DARK}};
        end else begin
            sr_q <= sr_d;
        end
    end

    assign msb_o = sr_q[WIDTH-1];

endmodule

// File: rtl/transmitter.sv
// MSB-first serializer driving one photonic lane modulator.
// Optional even-parity slot after each word when TX_PARITY_EN is defined.
module transmitter
    import transmitter_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] tx_in,
    input  logic             control,
    output logic             tx_out,
    output logic             tx_busy
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             sr_load;
    logic             sr_shift;
    logic [WIDTH-1:0] sr_data;
`ifdef TX_PARITY_EN
    logic             par_q, par_d;
`endif

    // Next-state, counter and shift-register control.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        sr_data  = tx_in;
`ifdef TX_PARITY_EN
        par_d    = par_q;
`endif
        case (state_q)
            TX_IDLE: begin
                if (control) begin
                    sr_load = 1'b1;
                    cnt_d   = CNT_LAST;
                    state_d = TX_SHIFT;
`ifdef TX_PARITY_EN
                    par_d   = ^tx_in;
`endif
                end
            end
            TX_SHIFT: begin
                if (cnt_q != '0) begin
                    sr_shift = 1'b1;
                    cnt_d    = cnt_q - CNT_W'(1);
                end else begin
`ifdef TX_PARITY_EN
                    // Parity bit is parked in the MSB so it drives the line next slot.
                    sr_load = 1'b1;
                    sr_data = WIDTH'(par_q) << (WIDTH - 1);
                    state_d = TX_PARITY;
`else
                    if (control) begin
                        sr_load = 1'b1;
                        cnt_d   = CNT_LAST;
                    end else begin
                        sr_shift = 1'b1;
                        state_d  = TX_IDLE;
                    end
`endif
                end
            end
`ifdef TX_PARITY_EN
            TX_PARITY: begin
                if (control) begin
                    sr_load = 1'b1;
                    cnt_d   = CNT_LAST;
                    par_d   = ^tx_in;
                    state_d = TX_SHIFT;
                end else begin
                    sr_shift = 1'b1;
                    state_d  = TX_IDLE;
                end
            end
`endif
            default: begin
                state_d = TX_IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != TX_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
`ifdef TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
`ifdef TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // The shift register's MSB flop is the line driver; it is all-zero when idle.
    tx_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift_reg (
        .clk     (clk),
        .clr_n_i (rst_n),
        .load_i  (sr_load),
        .shift_i (sr_shift),
        .data_i  (sr_data),
        .msb_o   (tx_out)
    );

    assign tx_busy = busy_q;

endmodule

// File: tb/tb_transmitter.sv
// Bench for transmitter: WIDTH=1 and WIDTH=4 instances against a bit-queue model.
module tb_transmitter;

`ifdef TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       control = 1'b0;
    logic [0:0] tx_in1 = '0;
    logic [3:0] tx_in4 = '0;
    logic       out1, busy1, out4, busy4;

    always #5 clk = ~clk;

    transmitter #(.WIDTH(1)) u_dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_in   (tx_in1),
        .control (control),
        .tx_out  (out1),
        .tx_busy (busy1)
    );

    transmitter #(.WIDTH(4)) u_dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_in   (tx_in4),
        .control (control),
        .tx_out  (out4),
        .tx_busy (busy4)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          q1[$];
    bit          q4[$];
    logic        e_o1, e_b1, e_o4, e_b4;
    logic [15:0] h_o1 = '0, h_b1 = '0, h_o4 = '0, h_b4 = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Queue holds bits still to be shown; an empty queue at an edge is a decision point.
    task automatic model(input int w, input logic [63:0] word, input logic ctl,
                         input logic rst, ref bit q[$], output logic o, output logic b);
        bit p;
        p = 1'b0;
        if (!rst) begin
            q.delete();
            o = 1'b0;
            b = 1'b0;
        end else if (q.size() == 0) begin
            if (ctl) begin
                for (int i = w - 1; i >= 0; i--) begin
                    q.push_back(word[i]);
                    p ^= word[i];
                end
                if (PAR) q.push_back(p);
                o = q.pop_front();
                b = 1'b1;
            end else begin
                o = 1'b0;
                b = 1'b0;
            end
        end else begin
            o = q.pop_front();
            b = 1'b1;
        end
    endtask

    task automatic step(input logic r, input logic c, input logic d1, input logic [3:0] d4);
        rst_n   = r;
        control = c;
        tx_in1  = d1;
        tx_in4  = d4;
        @(posedge clk);
        model(1, 64'(d1), c, r, q1, e_o1, e_b1);
        model(4, 64'(d4), c, r, q4, e_o4, e_b4);
        #1;
        check("w1_out",  64'(out1),  64'(e_o1));
        check("w1_busy", 64'(busy1), 64'(e_b1));
        check("w4_out",  64'(out4),  64'(e_o4));
        check("w4_busy", 64'(busy4), 64'(e_b4));
        h_o1 = {h_o1[14:0], out1};
        h_b1 = {h_b1[14:0], busy1};
        h_o4 = {h_o4[14:0], out4};
        h_b4 = {h_b4[14:0], busy4};
    endtask

    task automatic go_idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 4'h0);
    endtask

    initial begin
        step(1'b0, 1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b1, 1'b1, 4'hF);
        check("reset_out4",  64'(out4),  64'd0);
        check("reset_busy4", 64'(busy4), 64'd0);
        check("reset_out1",  64'(out1),  64'd0);

        // WIDTH=1 gated pass-through
        step(1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b0, 1'b1, 4'h0);
        step(1'b1, 1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b1, 4'h0);
`ifndef TX_PARITY_EN
        check("w1_pass_out",  64'(h_o1[3:0]), 64'(4'b0001));
`endif
        check("w1_pass_busy", 64'(h_b1[3:0]), 64'(4'b0011));
        go_idle(8);

        // Single word 1011
        step(1'b1, 1'b1, 1'b0, 4'b1011);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 4'($urandom));
`ifdef TX_PARITY_EN
        check("word_1011_out",  64'(h_o4[4:0]), 64'(5'b10111));
        check("word_1011_busy", 64'(h_b4[4:0]), 64'(5'b11111));
`else
        check("word_1011_out",  64'(h_o4[4:0]), 64'(5'b10110));
        check("word_1011_busy", 64'(h_b4[4:0]), 64'(5'b11110));
`endif
        go_idle(6);

        // Back-to-back A then 5 with control held high
        step(1'b1, 1'b1, 1'b0, 4'hA);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 4'($urandom));
        step(1'b1, 1'b1, 1'b0, 4'h5);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 4'($urandom));
`ifndef TX_PARITY_EN
        check("b2b_out",  64'(h_o4[7:0]), 64'(8'hA5));
        check("b2b_busy", 64'(h_b4[7:0]), 64'(8'hFF));
`endif
        go_idle(6);

        // Reset during the second bit, then a fresh word
        step(1'b1, 1'b1, 1'b0, 4'b1101);
        step(1'b1, 1'b1, 1'b0, 4'b0000);
        step(1'b0, 1'b1, 1'b0, 4'b0000);
        check("mid_rst_out",  64'(out4),  64'd0);
        check("mid_rst_busy", 64'(busy4), 64'd0);
        step(1'b1, 1'b1, 1'b0, 4'b1001);
        check("fresh_first", 64'(out4), 64'd1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 4'($urandom));
`ifndef TX_PARITY_EN
        check("fresh_word", 64'(h_o4[3:0]), 64'(4'b1001));
`endif
        go_idle(6);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 63) != 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom), 4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
